// File: rtl/ysyx_25020037_ifu.sv
// ysyx_25020037_ifu: multi-cycle instruction fetch unit.
// Holds the PC, fetches one word per retired instruction, hands it to decode.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wbu_valid, dnpc     next-PC strobe and value from write-back
//   idu_ready           decode stage can accept
//   ifu_valid, pc,
//   inst, fetch_err     presented instruction bundle
//   fetch_cnt           completed fetches (wraps)
//   ar*, r*             AXI4-Lite-style read channel to memory
module ysyx_25020037_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_valid,
  input  logic [31:0] dnpc,
  input  logic        idu_ready,
  output logic        ifu_valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  localparam logic [1:0] AR    = 2'd0;
  localparam logic [1:0] R     = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_n;
  logic       id_fire;
  logic       take_pc;
  logic       misalign;
  logic       rd_done;

  assign arvalid   = (state == AR);
  assign rready    = (state == R);
  assign ifu_valid = (state == VALID);
  assign araddr    = pc;
  assign arsize    = 3'b010;

  assign id_fire  = ifu_valid & idu_ready;
  // dnpc is accepted in WAIT, or in the same cycle decode takes the word.
  assign take_pc  = wbu_valid & ((state == WAIT) | id_fire);
  assign misalign = |dnpc[1:0];
  assign rd_done  = rvalid & rready;

  always_comb begin
    state_n = state;
    case (state)
      AR:      if (arready)   state_n = R;
      R:       if (rvalid)    state_n = VALID;
      VALID:   if (idu_ready) state_n = WAIT;
      default: state_n = state;
    endcase
    // A misaligned target never reaches memory; it is reported directly.
    if (take_pc)
      state_n = misalign ? VALID : AR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= AR;
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state <= state_n;
      if (take_pc)
        pc <= dnpc;
      if (rd_done) begin
        inst      <= (rresp != 2'b00) ? 32'h0 : rdata;
        fetch_err <= (rresp != 2'b00);
        fetch_cnt <= fetch_cnt + 32'd1;
      end else if (take_pc && misalign) begin
        inst      <= '0;
        fetch_err <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  // Write-back may only return a next PC once the fetch has been handed off.
  a_wbu_in_fetch : assert property (
    @(posedge clk) disable iff (rst)
      !(wbu_valid && ((state == AR) || (state == R)))
  );

endmodule
